pipe_scroller: RTL



---
 rtl/flappy_pkg.sv | 9 +
 rtl/pipe_scroller_scroll_divider.sv | 71 +++++++
 rtl/pipe_scroller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared types and default playfield geometry for the Flappy Bird display blocks.
package flappy_pkg;

  typedef enum logic {S_SPACE, S_PIPE} scroll_state_t;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;

endpackage

// File: rtl/pipe_scroller_scroll_divider.sv
// Scroll-rate divider: emits a tick every eff_div+1 enabled cycles.
// PIPE_SCROLLER_SPEEDUP_EN adds a score-driven speed level that shortens the period.
module scroll_divider
  import flappy_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_scroll_div,
  input  logic             i_score,
  output logic             o_tick,
  output logic [3:0]       o_speed_level
);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_eff_div;

`ifdef PIPE_SCROLLER_SPEEDUP_EN
  logic [3:0]     r_speed;
  logic [1:0]     r_score_cnt;
  logic [DIV_W:0] w_diff;

  // One extra bit so scroll_div < speed_level shows up as a negative result.
  assign w_diff = {1'b0, i_scroll_div} - {{(DIV_W-3){1'b0}}, r_speed};

  always_comb begin
    if (w_diff[DIV_W] || (w_diff < (DIV_W+1)'(MIN_DIV))) begin
      w_eff_div = DIV_W'(MIN_DIV);
    end else begin
      w_eff_div = w_diff[DIV_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_speed     <= '0;
      r_score_cnt <= '0;
    end else if (i_score) begin
      r_score_cnt <= r_score_cnt + 2'd1;
      if ((r_score_cnt == 2'd3) && (r_speed != 4'd15)) begin
        r_speed <= r_speed + 4'd1;
      end
    end
  end

  assign o_speed_level = r_speed;
`else
  logic [1:0] w_unused;

  assign w_unused      = {i_score, 1'(MIN_DIV)};
  assign w_eff_div     = i_scroll_div;
  assign o_speed_level = '0;
`endif

  // The >= compare lets a lowered divider take effect on the very next cycle.
  assign o_tick = i_enable && (r_div_cnt >= w_eff_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (o_tick) begin
      r_div_cnt <= '0;
    end else if (i_enable) begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Playfield scroll engine: shifts the obstacle map one column per tick and generates pipes.
// Optional score-driven speed-up is enabled with PIPE_SCROLLER_SPEEDUP_EN.
//
// state   | meaning
// S_SPACE | inserting empty columns between pipes
// S_PIPE  | inserting pipe columns with the latched gap opening
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int GAP_H     = 4,
  parameter int PIPE_W    = 2,
  parameter int SPACING   = 6,
  parameter int DIV_W     = 24,
  parameter int SCORE_COL = 4,
  parameter int MIN_DIV   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           scroll_div,
  input  logic [$clog2(ROWS)-1:0]    gap_pos,
  output logic [ROWS-1:0][COLS-1:0]  field,
  output logic                       scroll_tick,
  output logic                       pipe_spawn,
  output logic                       score_pulse,
  output logic [3:0]                 speed_level
);

  localparam int GP_W    = $clog2(ROWS);
  localparam int CNT_MAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [GP_W-1:0] GAP_MAX = GP_W'(ROWS - GAP_H);

  scroll_state_t             r_state;
  logic [CNT_W-1:0]          r_col_cnt;
  logic [GP_W-1:0]           r_gap_top;
  logic [ROWS-1:0][COLS-1:0] r_field;
  logic [COLS-1:0]           r_marker;
  logic                      r_scroll_tick;
  logic                      r_pipe_spawn;
  logic                      r_score_pulse;

  logic            w_tick;
  logic [ROWS-1:0] w_new_col;
  logic            w_first_col;
  logic            w_last_col;
  logic            w_unused_marker;

  scroll_divider #(
    .DIV_W   (DIV_W),
    .MIN_DIV (MIN_DIV)
  ) u_divider (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (enable),
    .i_scroll_div  (scroll_div),
    .i_score       (r_score_pulse),
    .o_tick        (w_tick),
    .o_speed_level (speed_level)
  );

  always_comb begin
    w_new_col = '0;
    if (r_state == S_PIPE) begin
      for (int r = 0; r < ROWS; r++) begin
        w_new_col[r] = !((r >= int'(r_gap_top)) && (r < int'(r_gap_top) + GAP_H));
      end
    end
  end

  assign w_first_col = (r_state == S_PIPE) && (r_col_cnt == '0);
  assign w_last_col  = (r_state == S_PIPE) && (r_col_cnt == CNT_W'(PIPE_W - 1));

  // The marker leaving the last column carries no information.
  assign w_unused_marker = r_marker[COLS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_SPACE;
      r_col_cnt     <= '0;
      r_gap_top     <= '0;
      r_field       <= '0;
      r_marker      <= '0;
      r_scroll_tick <= 1'b0;
      r_pipe_spawn  <= 1'b0;
      r_score_pulse <= 1'b0;
    end else begin
      r_scroll_tick <= 1'b0;
      r_pipe_spawn  <= 1'b0;
      r_score_pulse <= 1'b0;
      if (w_tick) begin
        for (int r = 0; r < ROWS; r++) begin
          r_field[r] <= {r_field[r][COLS-2:0], w_new_col[r]};
        end
        r_marker      <= {r_marker[COLS-2:0], w_last_col};
        r_scroll_tick <= 1'b1;
        r_pipe_spawn  <= w_first_col;
        r_score_pulse <= r_marker[SCORE_COL];
        case (r_state)
          S_SPACE: begin
            if (r_col_cnt == CNT_W'(SPACING - 1)) begin
              r_gap_top <= (gap_pos > GAP_MAX) ? GAP_MAX : gap_pos;
              r_col_cnt <= '0;
              r_state   <= S_PIPE;
            end else begin
              r_col_cnt <= r_col_cnt + CNT_W'(1);
            end
          end
          S_PIPE: begin
            if (r_col_cnt == CNT_W'(PIPE_W - 1)) begin
              r_col_cnt <= '0;
              r_state   <= S_SPACE;
            end else begin
              r_col_cnt <= r_col_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_SPACE;
        endcase
      end
    end
  end

  assign field       = r_field;
  assign scroll_tick = r_scroll_tick;
  assign pipe_spawn  = r_pipe_spawn;
  assign score_pulse = r_score_pulse;

endmodule
